// File: rtl/dmem_route.sv
// dmem_route: steers one outstanding data-memory request to either the
// cached or the uncached path, chosen by the PMA lookup at capture time.
// It returns the selected path's response, or a zero/err response if the
// path stays silent for TMO cycles.
module dmem_route #(
    parameter int unsigned ABITS = 48,
    parameter int unsigned TMO   = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,

    // request side
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [ABITS-1:0] i_req_addr,
    input  logic             i_req_write,
    input  logic [63:0]      i_req_wdata,
    input  logic [7:0]       i_req_wstrb,

    // PMA lookup
    output logic [ABITS-1:0] o_pma_daddr,
    input  logic             i_pma_dcached,

    // shared memory request payload
    output logic [ABITS-1:0] o_mem_addr,
    output logic             o_mem_write,
    output logic [63:0]      o_mem_wdata,
    output logic [7:0]       o_mem_wstrb,

    // cached path
    output logic             o_c_valid,
    input  logic             i_c_ready,
    input  logic             i_c_resp_valid,
    input  logic [63:0]      i_c_resp_data,
    input  logic             i_c_resp_err,

    // uncached path
    output logic             o_u_valid,
    input  logic             i_u_ready,
    input  logic             i_u_resp_valid,
    input  logic [63:0]      i_u_resp_data,
    input  logic             i_u_resp_err,

    // response side
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic [63:0]      o_resp_data,
    output logic             o_resp_err
);

    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] TMO_L   = CNT_W'(TMO);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // latched request and route
    logic [ABITS-1:0]   r_addr;
    logic               r_write;
    logic [63:0]        r_wdata;
    logic [7:0]         r_wstrb;
    logic               r_route;

    // timeout counter and latched response
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_rdata;
    logic               r_rerr;

    // registered handshake outputs
    logic               r_req_ready;
    logic               r_c_valid;
    logic               r_u_valid;
    logic               r_resp_valid;

    // FSM decode strobes
    logic               w_capture;
    logic               w_issue_done;
    logic               w_take_resp;
    logic               w_timeout;
    logic               w_route_nxt;

    // selected-path view
    logic               w_sel_ready;
    logic               w_sel_resp_valid;
    logic [63:0]        w_sel_resp_data;
    logic               w_sel_resp_err;

    // PMA lookup always sees the live request address
    assign o_pma_daddr  = i_req_addr;

    assign o_req_ready  = r_req_ready;
    assign o_c_valid    = r_c_valid;
    assign o_u_valid    = r_u_valid;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_rdata;
    assign o_resp_err   = r_rerr;

    assign o_mem_addr   = r_addr;
    assign o_mem_write  = r_write;
    assign o_mem_wdata  = r_wdata;
    assign o_mem_wstrb  = r_wstrb;

    // Pick the handshake/response signals of the path chosen at capture
    always_comb begin
        w_sel_ready      = 1'b0;
        w_sel_resp_valid = 1'b0;
        w_sel_resp_data  = 64'd0;
        w_sel_resp_err   = 1'b0;
        if (r_route) begin
            w_sel_ready      = i_c_ready;
            w_sel_resp_valid = i_c_resp_valid;
            w_sel_resp_data  = i_c_resp_data;
            w_sel_resp_err   = i_c_resp_err;
        end else begin
            w_sel_ready      = i_u_ready;
            w_sel_resp_valid = i_u_resp_valid;
            w_sel_resp_data  = i_u_resp_data;
            w_sel_resp_err   = i_u_resp_err;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a real response beats a timeout in the same cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_issue_done = 1'b0;
        w_take_resp  = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_sel_ready) begin
                    w_issue_done = 1'b1;
                    w_state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (w_sel_resp_valid) begin
                    w_take_resp = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_cnt >= TMO_L) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Route the next cycle will use, so the valids can be registered
    assign w_route_nxt = w_capture ? i_pma_dcached : r_route;

    // Request capture; the route bit is frozen until the next capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= 64'd0;
            r_wstrb <= 8'd0;
            r_route <= 1'b0;
        end else if (w_capture) begin
            r_addr  <= i_req_addr;
            r_write <= i_req_write;
            r_wdata <= i_req_wdata;
            r_wstrb <= i_req_wstrb;
            r_route <= i_pma_dcached;
        end
    end

    // Timeout counter: cleared on WAIT entry, saturating count while in WAIT
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_issue_done) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Response latch: path data, or zero with err on timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= 64'd0;
            r_rerr  <= 1'b0;
        end else if (w_take_resp) begin
            r_rdata <= w_sel_resp_data;
            r_rerr  <= w_sel_resp_err;
        end else if (w_timeout) begin
            r_rdata <= 64'd0;
            r_rerr  <= 1'b1;
        end
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_ready  <= 1'b1;
            r_c_valid    <= 1'b0;
            r_u_valid    <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_req_ready  <= (w_state_nxt == IDLE);
            r_c_valid    <= (w_state_nxt == ISSUE) &&  w_route_nxt;
            r_u_valid    <= (w_state_nxt == ISSUE) && !w_route_nxt;
            r_resp_valid <= (w_state_nxt == RESP);
        end
    end

endmodule

// File: tb/tb_dmem_route.sv
// tb_dmem_route: directed and randomized transactions against a
// transaction-level expectation of routing, latency and timeout.
module tb_dmem_route;

    localparam int unsigned ABITS = 48;
    localparam int unsigned TMO   = 4;

    logic             i_clk;
    logic             i_rst;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [ABITS-1:0] i_req_addr;
    logic             i_req_write;
    logic [63:0]      i_req_wdata;
    logic [7:0]       i_req_wstrb;
    logic [ABITS-1:0] o_pma_daddr;
    logic             i_pma_dcached;
    logic [ABITS-1:0] o_mem_addr;
    logic             o_mem_write;
    logic [63:0]      o_mem_wdata;
    logic [7:0]       o_mem_wstrb;
    logic             o_c_valid;
    logic             i_c_ready;
    logic             i_c_resp_valid;
    logic [63:0]      i_c_resp_data;
    logic             i_c_resp_err;
    logic             o_u_valid;
    logic             i_u_ready;
    logic             i_u_resp_valid;
    logic [63:0]      i_u_resp_data;
    logic             i_u_resp_err;
    logic             o_resp_valid;
    logic             i_resp_ready;
    logic [63:0]      o_resp_data;
    logic             o_resp_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    dmem_route #(.ABITS(ABITS), .TMO(TMO)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_write    (i_req_write),
        .i_req_wdata    (i_req_wdata),
        .i_req_wstrb    (i_req_wstrb),
        .o_pma_daddr    (o_pma_daddr),
        .i_pma_dcached  (i_pma_dcached),
        .o_mem_addr     (o_mem_addr),
        .o_mem_write    (o_mem_write),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wstrb    (o_mem_wstrb),
        .o_c_valid      (o_c_valid),
        .i_c_ready      (i_c_ready),
        .i_c_resp_valid (i_c_resp_valid),
        .i_c_resp_data  (i_c_resp_data),
        .i_c_resp_err   (i_c_resp_err),
        .o_u_valid      (o_u_valid),
        .i_u_ready      (i_u_ready),
        .i_u_resp_valid (i_u_resp_valid),
        .i_u_resp_data  (i_u_resp_data),
        .i_u_resp_err   (i_u_resp_err),
        .o_resp_valid   (o_resp_valid),
        .i_resp_ready   (i_resp_ready),
        .o_resp_data    (o_resp_data),
        .o_resp_err     (o_resp_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // free-running cycle count for latency measurement
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        i_req_valid    = 1'b0;
        i_c_ready      = 1'b0;
        i_u_ready      = 1'b0;
        i_c_resp_valid = 1'b0;
        i_u_resp_valid = 1'b0;
        i_resp_ready   = 1'b0;
    endtask

    // One request from capture to response handshake.
    // rsp_dly: WAIT cycle index where the selected path answers; <0 or >TMO = never.
    task automatic run_txn(input logic [ABITS-1:0] addr, input logic wr,
                           input logic [63:0] wd, input logic [7:0] ws,
                           input logic cached, input int rdy_dly, input int rsp_dly,
                           input logic [63:0] rd, input logic re, input logic stray,
                           input string nm);
        logic        tmo;
        int          widx;
        logic [63:0] exp_d;
        logic        exp_e;
        int          t0;
        int          hold;
        tmo   = (rsp_dly < 0) || (rsp_dly > int'(TMO));
        widx  = tmo ? int'(TMO) : rsp_dly;
        exp_d = tmo ? 64'd0 : rd;
        exp_e = tmo ? 1'b1 : re;

        chk({nm, ":idle_ready"}, 64'(o_req_ready), 64'd1);
        i_req_valid   = 1'b1;
        i_req_addr    = addr;
        i_req_write   = wr;
        i_req_wdata   = wd;
        i_req_wstrb   = ws;
        i_pma_dcached = cached;
        t0 = cyc;
        @(negedge i_clk);

        // scramble live inputs: captured values must not follow them
        i_req_valid   = 1'b0;
        i_req_addr    = ABITS'({$urandom, $urandom});
        i_req_write   = ~wr;
        i_req_wdata   = {$urandom, $urandom};
        i_req_wstrb   = 8'($urandom);
        i_pma_dcached = ~cached;
        chk({nm, ":pma_daddr"}, 64'(o_pma_daddr), 64'(i_req_addr));

        for (int k = 0; k <= rdy_dly; k++) begin
            chk({nm, ":c_valid"}, 64'(o_c_valid), 64'(cached));
            chk({nm, ":u_valid"}, 64'(o_u_valid), 64'(!cached));
            chk({nm, ":issue_ready"}, 64'(o_req_ready), 64'd0);
            chk({nm, ":mem_addr"}, 64'(o_mem_addr), 64'(addr));
            chk({nm, ":mem_wdata"}, o_mem_wdata, wd);
            chk({nm, ":mem_wstrb"}, 64'(o_mem_wstrb), 64'(ws));
            chk({nm, ":mem_write"}, 64'(o_mem_write), 64'(wr));
            if (cached) begin
                i_c_ready = (k == rdy_dly);
                i_u_ready = 1'b1;
            end else begin
                i_u_ready = (k == rdy_dly);
                i_c_ready = 1'b1;
            end
            @(negedge i_clk);
        end
        i_c_ready = 1'b0;
        i_u_ready = 1'b0;

        for (int w = 0; w <= widx; w++) begin
            chk({nm, ":wait_flags"},
                64'({o_c_valid, o_u_valid, o_resp_valid, o_req_ready}), 64'd0);
            chk({nm, ":wait_mem_addr"}, 64'(o_mem_addr), 64'(addr));
            if (stray && w == 0) begin
                if (cached) begin
                    i_u_resp_valid = 1'b1;
                    i_u_resp_data  = {$urandom, $urandom};
                    i_u_resp_err   = 1'b1;
                end else begin
                    i_c_resp_valid = 1'b1;
                    i_c_resp_data  = {$urandom, $urandom};
                    i_c_resp_err   = 1'b1;
                end
            end
            if (!tmo && w == widx) begin
                if (cached) begin
                    i_c_resp_valid = 1'b1;
                    i_c_resp_data  = rd;
                    i_c_resp_err   = re;
                end else begin
                    i_u_resp_valid = 1'b1;
                    i_u_resp_data  = rd;
                    i_u_resp_err   = re;
                end
            end
            @(negedge i_clk);
            i_c_resp_valid = 1'b0;
            i_u_resp_valid = 1'b0;
        end

        chk({nm, ":latency"}, 64'(cyc - t0), 64'(3 + rdy_dly + widx));
        hold = int'($urandom_range(0, 2));
        for (int h = 0; h <= hold; h++) begin
            chk({nm, ":resp_valid"}, 64'(o_resp_valid), 64'd1);
            chk({nm, ":resp_data"}, o_resp_data, exp_d);
            chk({nm, ":resp_err"}, 64'(o_resp_err), 64'(exp_e));
            chk({nm, ":resp_mem_addr"}, 64'(o_mem_addr), 64'(addr));
            i_resp_ready = (h == hold);
            if (h == 0) begin
                i_c_resp_valid = 1'b1;
                i_u_resp_valid = 1'b1;
                i_c_resp_data  = {$urandom, $urandom};
                i_u_resp_data  = {$urandom, $urandom};
                i_c_resp_err   = ~exp_e;
                i_u_resp_err   = ~exp_e;
            end
            @(negedge i_clk);
            i_c_resp_valid = 1'b0;
            i_u_resp_valid = 1'b0;
        end
        i_resp_ready = 1'b0;
        chk({nm, ":done_resp_valid"}, 64'(o_resp_valid), 64'd0);
        chk({nm, ":done_ready"}, 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        quiet();
        i_rst         = 1'b1;
        i_req_addr    = '0;
        i_req_write   = 1'b0;
        i_req_wdata   = 64'd0;
        i_req_wstrb   = 8'd0;
        i_pma_dcached = 1'b0;
        i_c_resp_data = 64'd0;
        i_c_resp_err  = 1'b0;
        i_u_resp_data = 64'd0;
        i_u_resp_err  = 1'b0;
        repeat (2) @(negedge i_clk);

        chk("rst_valids", 64'({o_c_valid, o_u_valid, o_resp_valid, o_resp_err, o_mem_write}), 64'd0);
        chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_ready", 64'(o_req_ready), 64'd1);
        chk("post_rst_valids", 64'({o_c_valid, o_u_valid, o_resp_valid, o_resp_err}), 64'd0);
        chk("post_rst_wdata", o_mem_wdata, 64'd0);
        chk("post_rst_wstrb", 64'(o_mem_wstrb), 64'd0);
        chk("post_rst_rdata", o_resp_data, 64'd0);

        // cached read, minimum latency
        run_txn(48'h0000_8000_0000, 1'b0, 64'd0, 8'h00, 1'b1, 0, 0,
                64'h1122_3344_5566_7788, 1'b0, 1'b0, "cached_read");
        // uncached CLINT write
        run_txn(48'h0000_0200_0000, 1'b1, 64'h0000_0000_CAFE_F00D, 8'h0F, 1'b0, 0, 1,
                64'h0000_0000_0000_0001, 1'b0, 1'b0, "uncached_write");
        // ready held low 5 cycles: valid visible for 6
        run_txn(48'h0000_0200_4000, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1'b0, 5, 0,
                64'h0000_0000_0000_0042, 1'b0, 1'b0, "backpressure");
        // timeout with no response
        run_txn(48'h0000_1000_0000, 1'b0, 64'd0, 8'h00, 1'b0, 0, -1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "timeout");
        // response coincides with timeout: response wins
        run_txn(48'h0000_1000_0008, 1'b0, 64'd0, 8'h00, 1'b0, 0, int'(TMO),
                64'h0BAD_BEEF_1234_5678, 1'b0, 1'b0, "tmo_race_u");
        run_txn(48'h0000_8000_0040, 1'b0, 64'd0, 8'h00, 1'b1, 1, int'(TMO),
                64'h7777_0000_8888_0000, 1'b1, 1'b0, "tmo_race_c");
        // stray cached response while routed uncached
        run_txn(48'h0000_0200_0008, 1'b0, 64'd0, 8'h00, 1'b0, 0, 2,
                64'h5555_6666_7777_8888, 1'b0, 1'b1, "stray");

        // reset during WAIT drops the transaction
        i_req_valid   = 1'b1;
        i_req_addr    = 48'h0000_0200_0010;
        i_req_write   = 1'b1;
        i_req_wdata   = 64'h1234_5678_9ABC_DEF0;
        i_req_wstrb   = 8'hF0;
        i_pma_dcached = 1'b0;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_u_ready   = 1'b1;
        @(negedge i_clk);
        i_u_ready = 1'b0;
        @(negedge i_clk);
        chk("rw_in_wait", 64'({o_u_valid, o_resp_valid, o_req_ready}), 64'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rw_ready", 64'(o_req_ready), 64'd1);
        chk("rw_valids", 64'({o_c_valid, o_u_valid, o_resp_valid, o_resp_err, o_mem_write}), 64'd0);
        chk("rw_mem_addr", 64'(o_mem_addr), 64'd0);
        chk("rw_mem_wdata", o_mem_wdata, 64'd0);
        chk("rw_mem_wstrb", 64'(o_mem_wstrb), 64'd0);
        i_u_resp_valid = 1'b1;
        i_u_resp_data  = 64'hDEAD_DEAD_DEAD_DEAD;
        i_u_resp_err   = 1'b1;
        @(negedge i_clk);
        i_u_resp_valid = 1'b0;
        chk("rw_late_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rw_late_ready", 64'(o_req_ready), 64'd1);
        chk("rw_late_data", o_resp_data, 64'd0);
        @(negedge i_clk);
        chk("rw_still_idle", 64'({o_c_valid, o_u_valid, o_resp_valid}), 64'd0);

        // randomized transactions
        for (int t = 0; t < 24; t++) begin
            run_txn(ABITS'({$urandom, $urandom}), 1'($urandom), {$urandom, $urandom},
                    8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 7)) - 1, {$urandom, $urandom},
                    1'($urandom), 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
